// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package if_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 4;
   localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = 8'h00;

   typedef enum logic [1:0] {
      S_START = 2'd0,
      S_FETCH = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   // Queue entry layout: pc in the upper bits, instruction in the lower bits.
   typedef struct packed {
      logic [ADDR_W_DEF-1:0] pc;
      logic [DATA_W_DEF-1:0] instr;
   } entry_t;

endpackage

// File: rtl/if_queue.sv
// Prefetch FIFO: DEPTH entries, flush beats push/pop, push+pop legal when full.
module if_queue #(
   parameter int W     = 16,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  logic [W-1:0]  wdata_i,
   output logic [W-1:0]  rdata_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wptr_q;
   logic [PW-1:0] rptr_q;
   logic [CW-1:0] count_q;
   logic          do_push_s;
   logic          do_pop_s;

   assign empty_o   = (count_q == {CW{1'b0}});
   assign full_o    = (count_q == CW'(DEPTH));
   assign count_o   = count_q;
   assign do_pop_s  = pop_i && !empty_o;
   assign do_push_s = push_i && (!full_o || do_pop_s);
   assign rdata_o   = empty_o ? {W{1'b0}} : mem_q[rptr_q];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wptr_q  <= {PW{1'b0}};
         rptr_q  <= {PW{1'b0}};
         count_q <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {W{1'b0}};
         end
      end else if (flush_i) begin
         wptr_q  <= {PW{1'b0}};
         rptr_q  <= {PW{1'b0}};
         count_q <= {CW{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_q[wptr_q] <= wdata_i;
            wptr_q        <= wptr_q + {{(PW-1){1'b0}}, 1'b1};
         end
         if (do_pop_s) begin
            rptr_q <= rptr_q + {{(PW-1){1'b0}}, 1'b1};
         end
         count_q <= count_q + CW'(do_push_s) - CW'(do_pop_s);
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch unit: drives the IM address from the fetch PC, queues
// returned bytes with their address, and supports branch redirect with flush.
module if_fetch
   import if_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              CLK,
   input  logic              RST_N,
   output logic [ADDR_W-1:0] ABUS,
   input  logic [DATA_W-1:0] DATABUS,
   input  logic              EN,
   input  logic              BR_VALID,
   input  logic [ADDR_W-1:0] BR_TARGET,
   output logic [DATA_W-1:0] INSTR,
   output logic [ADDR_W-1:0] INSTR_PC,
   output logic              INSTR_VALID,
   input  logic              INSTR_READY
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int W  = ADDR_W + DATA_W;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic              push_s;
   logic              pop_s;
   logic              full_s;
   logic              empty_s;
   logic [CW-1:0]     count_s;
   logic [W-1:0]      rdata_s;

   assign ABUS        = pc_q;
   assign INSTR_VALID = !empty_s;
   assign INSTR_PC    = rdata_s[W-1 -: ADDR_W];
   assign INSTR       = rdata_s[DATA_W-1:0];
   assign pop_s       = INSTR_VALID && INSTR_READY;
   // A redirect discards the byte sampled this cycle.
   assign push_s      = !BR_VALID && (state_q == S_FETCH) && EN && (!full_s || pop_s);

   if_queue #(
      .W     (W),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_queue (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .flush_i (BR_VALID),
      .wdata_i ({pc_q, DATABUS}),
      .rdata_o (rdata_s),
      .count_o (count_s),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (BR_VALID) begin
         pc_d    = BR_TARGET;
         state_d = S_FETCH;
      end else begin
         case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
               if (push_s) begin
                  pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               end else begin
                  pc_d = pc_q;
               end
               if (push_s && !pop_s && (count_s == CW'(DEPTH - 1))) begin
                  state_d = S_FULL;
               end else begin
                  state_d = S_FETCH;
               end
            end
            S_FULL: begin
               if (pop_s) begin
                  state_d = S_FETCH;
               end else begin
                  state_d = S_FULL;
               end
            end
            default: state_d = S_START;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_START;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed and randomized bench for if_fetch against a queue-based reference model.
module tb_if_fetch;
   import if_pkg::*;

   localparam int DEPTH = 4;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic [7:0] ABUS;
   logic [7:0] DATABUS;
   logic       EN;
   logic       BR_VALID;
   logic [7:0] BR_TARGET;
   logic [7:0] INSTR;
   logic [7:0] INSTR_PC;
   logic       INSTR_VALID;
   logic       INSTR_READY;

   logic [7:0] ram [256];
   assign DATABUS = ram[ABUS];

   always #5 CLK = ~CLK;

   if_fetch #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .ABUS        (ABUS),
      .DATABUS     (DATABUS),
      .EN          (EN),
      .BR_VALID    (BR_VALID),
      .BR_TARGET   (BR_TARGET),
      .INSTR       (INSTR),
      .INSTR_PC    (INSTR_PC),
      .INSTR_VALID (INSTR_VALID),
      .INSTR_READY (INSTR_READY)
   );

   // Reference model: a list of queued {pc, instr}, the fetch PC, and two flags
   // for the post-reset settle cycle and the full-hold condition.
   entry_t     mq[$];
   logic [7:0] mpc;
   bit         m_start;
   bit         m_hold;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      logic [7:0] e_instr;
      logic [7:0] e_pc;
      e_instr = (mq.size() > 0) ? mq[0].instr : 8'h00;
      e_pc    = (mq.size() > 0) ? mq[0].pc    : 8'h00;
      chk({ctx, ":abus"},  32'(ABUS),        32'(mpc));
      chk({ctx, ":valid"}, 32'(INSTR_VALID), 32'(mq.size() > 0));
      chk({ctx, ":instr"}, 32'(INSTR),       32'(e_instr));
      chk({ctx, ":ipc"},   32'(INSTR_PC),    32'(e_pc));
      chk({ctx, ":count"}, 32'(dut.count_s), 32'(mq.size()));
   endtask

   task automatic model_reset();
      mq.delete();
      mpc     = 8'h00;
      m_start = 1'b1;
      m_hold  = 1'b0;
   endtask

   task automatic model_edge(input bit en, input bit ready, input bit br, input logic [7:0] tgt);
      bit     pop;
      bit     cap;
      entry_t e;
      pop = (mq.size() > 0) && ready;
      if (br) begin
         mq.delete();
         mpc     = tgt;
         m_start = 1'b0;
         m_hold  = 1'b0;
      end else if (m_start) begin
         m_start = 1'b0;
      end else if (m_hold) begin
         if (pop) begin
            void'(mq.pop_front());
            m_hold = 1'b0;
         end
      end else begin
         cap = en && ((mq.size() < DEPTH) || pop);
         if (pop) void'(mq.pop_front());
         if (cap) begin
            e.pc    = mpc;
            e.instr = ram[mpc];
            mq.push_back(e);
            mpc = mpc + 8'd1;
         end
         m_hold = (mq.size() == DEPTH);
      end
   endtask

   task automatic step(input string ctx, input bit en, input bit ready, input bit br, input logic [7:0] tgt);
      EN          = en;
      INSTR_READY = ready;
      BR_VALID    = br;
      BR_TARGET   = tgt;
      @(posedge CLK);
      model_edge(en, ready, br, tgt);
      #1;
      check_all(ctx);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
      RST_N = 1'b0; EN = 1'b0; BR_VALID = 1'b0; BR_TARGET = 8'h00; INSTR_READY = 1'b0;
      model_reset();
      #1;
      check_all("reset");
      #11 RST_N = 1'b1;

      // streaming with decode always ready
      for (int i = 0; i < 8; i++) step("stream", 1'b1, 1'b1, 1'b0, 8'h00);
      // decode stalls: queue fills and ABUS holds
      for (int i = 0; i < 10; i++) step("stall", 1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 6; i++) step("drain", 1'b1, 1'b1, 1'b0, 8'h00);
      // PC wrap at 8'hFF
      step("wrap_br", 1'b1, 1'b1, 1'b1, 8'hFE);
      for (int i = 0; i < 6; i++) step("wrap", 1'b1, 1'b1, 1'b0, 8'h00);
      // redirect with three entries queued
      step("fill_br", 1'b1, 1'b0, 1'b1, 8'h10);
      for (int i = 0; i < 8 && mq.size() != 3; i++) step("fill3", 1'b1, 1'b0, 1'b0, 8'h00);
      step("br40", 1'b1, 1'b0, 1'b1, 8'h40);
      for (int i = 0; i < 4; i++) step("after40", 1'b1, 1'b1, 1'b0, 8'h00);
      // redirect coinciding with a pop on a full queue
      for (int i = 0; i < 8; i++) step("fill4", 1'b1, 1'b0, 1'b0, 8'h00);
      step("br_full_pop", 1'b1, 1'b1, 1'b1, 8'h80);
      for (int i = 0; i < 4; i++) step("after80", 1'b1, 1'b1, 1'b0, 8'h00);
      // fetch disabled while decode drains
      for (int i = 0; i < 6; i++) step("en_off", 1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) step("en_on", 1'b1, 1'b0, 1'b0, 8'h00);
      // half-cycle reset mid-stream
      RST_N = 1'b0;
      #2;
      model_reset();
      check_all("mid_rst");
      #2 RST_N = 1'b1;
      for (int i = 0; i < 6; i++) step("restart", 1'b1, 1'b1, 1'b0, 8'h00);
      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         step("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
